// File: rtl/alu_issue_if.sv
// Request/result/ALU-side bundle for alu_issue_stage.
// dz_count exists only when ALU_DZ_CNT_EN is defined.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_sel;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_res;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [2:0]  out_sel;
  logic        out_zero;
  logic        out_dz;
`ifdef ALU_DZ_CNT_EN
  logic [7:0]  dz_count;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_res, out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
           out_valid, out_res, out_sel, out_zero, out_dz
`ifdef ALU_DZ_CNT_EN
    , output dz_count
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_res, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
           out_valid, out_res, out_sel, out_zero, out_dz
`ifdef ALU_DZ_CNT_EN
    , input dz_count
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-entry issue/retire pipeline around a combinational 8-bit ALU.
// Optional divide-by-zero counter enabled by defining ALU_DZ_CNT_EN.
module alu_issue_stage #(
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [2:0] SEL_DIV = 3'b011;

  function automatic logic div_by_zero(input logic [2:0] sel, input logic [7:0] b);
    return (sel == SEL_DIV) && (b == 8'h00);
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [2:0]  op_sel_q, op_sel_d;

  logic        s2_valid_q, s2_valid_d;
  logic [15:0] out_res_q, out_res_d;
  logic [2:0]  out_sel_q, out_sel_d;
  logic        out_zero_q, out_zero_d;
  logic        out_dz_q, out_dz_d;

  logic        s1_adv_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        capture_s;
  logic        cap_dz_s;

  // Stage 1 may move on whenever stage 2 is empty or drains this cycle.
  always_comb begin
    s1_adv_s   = !s2_valid_q || bus.out_ready;
    in_ready_s = !s1_valid_q || s1_adv_s;
    accept_s   = bus.in_valid && in_ready_s;
    capture_s  = s1_valid_q && s1_adv_s;
    cap_dz_s   = div_by_zero(op_sel_q, op_b_q);
  end

  // Operand register next state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      op_a_d     = bus.in_a;
      op_b_d     = bus.in_b;
      op_sel_d   = bus.in_sel;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Result register next state; the held result is untouched while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_res_d  = out_res_q;
    out_sel_d  = out_sel_q;
    out_zero_d = out_zero_q;
    out_dz_d   = out_dz_q;
    if (capture_s) begin
      s2_valid_d = 1'b1;
      out_res_d  = bus.alu_res;
      out_sel_d  = op_sel_q;
      out_zero_d = (bus.alu_res == 16'h0000);
      out_dz_d   = cap_dz_s;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      op_a_q     <= 8'h00;
      op_b_q     <= 8'h00;
      op_sel_q   <= 3'b000;
      s2_valid_q <= 1'b0;
      out_res_q  <= 16'h0000;
      out_sel_q  <= 3'b000;
      out_zero_q <= 1'b0;
      out_dz_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      s2_valid_q <= s2_valid_d;
      out_res_q  <= out_res_d;
      out_sel_q  <= out_sel_d;
      out_zero_q <= out_zero_d;
      out_dz_q   <= out_dz_d;
    end
  end

`ifdef ALU_DZ_CNT_EN
  logic [7:0] dz_cnt_q, dz_cnt_d;

  // Saturating count of divide-by-zero results entering stage 2.
  always_comb begin
    dz_cnt_d = dz_cnt_q;
    if (capture_s && cap_dz_s && (dz_cnt_q != 8'hFF)) begin
      dz_cnt_d = dz_cnt_q + 8'h01;
    end else begin
      dz_cnt_d = dz_cnt_q;
    end
  end

  // Divide-by-zero counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_cnt_q <= 8'h00;
    end else begin
      dz_cnt_q <= dz_cnt_d;
    end
  end

  assign bus.dz_count = dz_cnt_q;
`endif

  // ALU drive: optionally parked at zero while no operand is held.
  always_comb begin
    if (IDLE_ZERO && !s1_valid_q) begin
      bus.alu_a   = 8'h00;
      bus.alu_b   = 8'h00;
      bus.alu_sel = 3'b000;
    end else begin
      bus.alu_a   = op_a_q;
      bus.alu_b   = op_b_q;
      bus.alu_sel = op_sel_q;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_dz    = out_dz_q;

endmodule
